// File: rtl/gate_resp_checker_pkg.sv
// Shared definitions for the gate response checker: gate op codes, FSM states
// and the reference model of each two-input gate.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Unassigned codes 6 and 7 expect a constant 0.
    function automatic logic gate_expected(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_resp_checker_if.sv
// Run control, observed gate vector and result signals between a gate bench and the checker.
interface gate_resp_checker_if #(parameter int CNT_W = 16);
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [1:0]       first_fail_ab;

    modport master (
        output start, op, num_vec, in_valid, a, b, dut_out,
        input  busy, done, pass, err_cnt, vec_cnt, first_fail_idx, first_fail_ab
    );

    modport slave (
        input  start, op, num_vec, in_valid, a, b, dut_out,
        output busy, done, pass, err_cnt, vec_cnt, first_fail_idx, first_fail_ab
    );
endinterface

// File: rtl/gate_resp_checker_delay.sv
// LAT-deep shift register aligning a checked vector with the gate output it produced.
// Valid bits clear asynchronously; payload bits are plain data registers.
module gate_chk_delay #(
    parameter int LAT = 0,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    // At LAT=0 one stage still exists but is bypassed, so it has no load.
    localparam int D = (LAT > 0) ? LAT : 1;

    logic         vld_q [D];
    logic [W-1:0] dat_q [D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) vld_q[i] <= 1'b0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < D; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_data;
        for (int i = 1; i < D; i++) dat_q[i] <= dat_q[i-1];
    end

    assign out_valid = (LAT == 0) ? in_valid : vld_q[D-1];
    assign out_data  = (LAT == 0) ? in_data  : dat_q[D-1];
endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for two-input gate benches: predicts each vector's result,
// compares it LAT cycles later against the gate output and keeps run statistics.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int LAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_resp_checker_if.slave   bus
);
    localparam int PW = CNT_W + 3;

    state_e           state, state_n;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] num_q, issued, err_cnt, vec_cnt, ff_idx, vec_cnt_inc, idx_p;
    logic [1:0]       ff_ab;
    logic             pass_q;
    logic             accept, start_ok, pipe_valid, cmp_valid, mismatch, last_cmp;
    logic             exp_p, a_p, b_p;
    logic [PW-1:0]    push_data, cmp_data;

    assign start_ok  = (state == S_IDLE) && bus.start;
    assign accept    = (state == S_RUN) && bus.in_valid && (issued < num_q);
    assign push_data = {gate_expected(op_q, bus.a, bus.b), bus.a, bus.b, issued};

    gate_chk_delay #(.LAT(LAT), .W(PW)) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (push_data),
        .out_valid (pipe_valid),
        .out_data  (cmp_data)
    );

    assign {exp_p, a_p, b_p, idx_p} = cmp_data;
    assign cmp_valid   = pipe_valid && (state == S_RUN);
    assign mismatch    = cmp_valid && (bus.dut_out != exp_p);
    assign vec_cnt_inc = vec_cnt + CNT_W'(1);
    assign last_cmp    = cmp_valid && (vec_cnt_inc == num_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_n = (bus.num_vec == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                bus.busy = 1'b1;
                if (last_cmp) state_n = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            num_q   <= '0;
            issued  <= '0;
            err_cnt <= '0;
            vec_cnt <= '0;
            ff_idx  <= '0;
            ff_ab   <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                op_q    <= bus.op;
                num_q   <= bus.num_vec;
                issued  <= '0;
                err_cnt <= '0;
                vec_cnt <= '0;
                ff_idx  <= '0;
                ff_ab   <= '0;
                pass_q  <= (bus.num_vec == '0);
            end
            if (accept) issued <= issued + CNT_W'(1);
            if (cmp_valid) begin
                vec_cnt <= vec_cnt_inc;
                // err_cnt never returns to zero within a run, so zero marks "no failure yet".
                if (mismatch) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    if (err_cnt == '0) begin
                        ff_idx <= idx_p;
                        ff_ab  <= {a_p, b_p};
                    end
                end
                if (last_cmp) pass_q <= !mismatch && (err_cnt == '0);
            end
        end
    end

    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_cnt;
    assign bus.vec_cnt        = vec_cnt;
    assign bus.first_fail_idx = ff_idx;
    assign bus.first_fail_ab  = ff_ab;
endmodule
